// File: rtl/call_scheduler.sv
// call_scheduler
//   Turns floor-button presses into a single registered target floor for the
//   cabin movement controller. Latches calls, detects arrival from the
//   reported cabin position/motion, times the door-open dwell, clears served
//   calls and chooses the next target with a direction-preserving (collective)
//   policy over three floors.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn[2:0]    call buttons (level), bit i = floor i+1
//   cur_floor   cabin position, LABEL_Fx encoding (any other code = invalid)
//   moving      1 while the cabin is in motion
//   door_hold   (only with CALL_SCHED_DOOR_HOLD_EN) freezes the dwell count
//   goal_floor  registered target floor for the movement controller
//   goal_valid  registered, goal_floor carries a pending call
//   req_led     pending-call indicators, bit i = floor i+1
//   door_open   registered door-open command during dwell
//
// Optional feature macro: CALL_SCHED_DOOR_HOLD_EN (adds door_hold).
module call_scheduler #(
  parameter logic [1:0]  LABEL_F1     = 2'b00,
  parameter logic [1:0]  LABEL_F2     = 2'b01,
  parameter logic [1:0]  LABEL_F3     = 2'b10,
  parameter int unsigned DWELL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn,
  input  logic [1:0] cur_floor,
  input  logic       moving,
`ifdef CALL_SCHED_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic [1:0] goal_floor,
  output logic       goal_valid,
  output logic [2:0] req_led,
  output logic       door_open
);

  localparam int unsigned CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_DWELL} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [2:0]    pending_q, pending_d;
  logic [2:0]    btn_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    goal_floor_q, goal_floor_d;
  logic          goal_valid_q, goal_valid_d;
  logic          door_open_q, door_open_d;

  // Label -> ordinal (0..2); 3 marks an unrecognised code.
  function automatic logic [1:0] to_idx(input logic [1:0] code);
    if (code == LABEL_F1)      return 2'd0;
    else if (code == LABEL_F2) return 2'd1;
    else if (code == LABEL_F3) return 2'd2;
    else                       return 2'd3;
  endfunction

  function automatic logic [1:0] to_label(input logic [1:0] idx);
    case (idx)
      2'd0:    return LABEL_F1;
      2'd1:    return LABEL_F2;
      default: return LABEL_F3;
    endcase
  endfunction

  // Lowest set floor (nearest when travelling up from below the mask).
  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  // Highest set floor (nearest when travelling down from above the mask).
  function automatic logic [1:0] highest(input logic [2:0] m);
    if (m[2])      return 2'd2;
    else if (m[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  logic [1:0] cur_idx, goal_idx;
  logic       cur_ok;
  logic [2:0] cur_oh, rise;
  logic [2:0] above_m, below_m, between_m;
  logic [2:0] pend_above, pend_below, pend_between;
  logic       arrived, hold;

  assign cur_idx  = to_idx(cur_floor);
  assign goal_idx = to_idx(goal_floor_q);
  assign cur_ok   = (cur_idx != 2'd3);
  assign cur_oh   = cur_ok ? (3'b001 << cur_idx) : 3'b000;
  assign rise     = btn & ~btn_q;
  assign arrived  = (cur_floor == goal_floor_q) && !moving;

`ifdef CALL_SCHED_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Floors above/below the cabin, and strictly between cabin and goal
  // (in the current travel direction) for mid-trip retargeting.
  always_comb begin
    above_m   = 3'b000;
    below_m   = 3'b000;
    between_m = 3'b000;
    for (int i = 0; i < 3; i++) begin
      above_m[i] = cur_ok && (2'(i) > cur_idx);
      below_m[i] = cur_ok && (2'(i) < cur_idx);
      if (state_q == ST_DOWN)
        between_m[i] = below_m[i] && (2'(i) > goal_idx);
      else
        between_m[i] = above_m[i] && (2'(i) < goal_idx);
    end
  end

  assign pend_above   = pending_q & above_m;
  assign pend_below   = pending_q & below_m;
  assign pend_between = pending_q & between_m;

  always_comb begin
    logic [2:0] serve_m;  // floors whose call is served/suppressed this cycle
    state_d      = state_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    goal_floor_d = goal_floor_q;
    serve_m      = 3'b000;

    // Invalid position: everything frozen except call capture.
    if (cur_ok) begin
      case (state_q)
        ST_IDLE: begin
          if (!moving && (((rise | pending_q) & cur_oh) != 3'b000)) begin
            state_d = ST_DWELL;
            cnt_d   = DWELL_LOAD;
            serve_m = cur_oh;
          end else if ((pend_above | pend_below) != 3'b000) begin
            if ((pend_above != 3'b000) && (dir_q == DIR_UP || pend_below == 3'b000)) begin
              state_d      = ST_UP;
              goal_floor_d = to_label(lowest(pend_above));
            end else begin
              state_d      = ST_DOWN;
              goal_floor_d = to_label(highest(pend_below));
            end
          end
        end
        ST_UP, ST_DOWN: begin
          if (arrived) begin
            state_d = ST_DWELL;
            dir_d   = (state_q == ST_UP) ? DIR_UP : DIR_DOWN;
            cnt_d   = DWELL_LOAD;
            serve_m = cur_oh;
          end else if (pend_between != 3'b000) begin
            goal_floor_d = (state_q == ST_UP) ? to_label(lowest(pend_between))
                                              : to_label(highest(pend_between));
          end
        end
        default: begin  // ST_DWELL: presses at this floor extend the dwell
          serve_m = cur_oh;
          if ((rise & cur_oh) != 3'b000) begin
            cnt_d = DWELL_LOAD;
          end else if (hold) begin
            cnt_d = cnt_q;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (dir_q == DIR_UP && pend_above != 3'b000) begin
            state_d      = ST_UP;
            goal_floor_d = to_label(lowest(pend_above));
          end else if (dir_q == DIR_DOWN && pend_below != 3'b000) begin
            state_d      = ST_DOWN;
            goal_floor_d = to_label(highest(pend_below));
          end else if (pend_below != 3'b000) begin
            state_d      = ST_DOWN;
            dir_d        = DIR_DOWN;
            goal_floor_d = to_label(highest(pend_below));
          end else if (pend_above != 3'b000) begin
            state_d      = ST_UP;
            dir_d        = DIR_UP;
            goal_floor_d = to_label(lowest(pend_above));
          end else begin
            state_d = ST_IDLE;
          end
        end
      endcase
      if (state_d == ST_IDLE || state_d == ST_DWELL)
        goal_floor_d = cur_floor;
    end

    // Set-then-clear: a capture coinciding with service of the same floor
    // leaves the call cleared.
    pending_d    = (pending_q | rise) & ~serve_m;
    goal_valid_d = cur_ok && (state_d == ST_UP || state_d == ST_DOWN);
    door_open_d  = cur_ok && (state_d == ST_DWELL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_UP;
      pending_q    <= 3'b000;
      btn_q        <= 3'b000;
      cnt_q        <= '0;
      goal_floor_q <= LABEL_F1;
      goal_valid_q <= 1'b0;
      door_open_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      btn_q        <= btn;
      cnt_q        <= cnt_d;
      goal_floor_q <= goal_floor_d;
      goal_valid_q <= goal_valid_d;
      door_open_q  <= door_open_d;
    end
  end

  assign goal_floor = goal_floor_q;
  assign goal_valid = goal_valid_q;
  assign req_led    = pending_q;
  assign door_open  = door_open_q;

endmodule

// File: tb/tb_call_scheduler.sv
module tb_call_scheduler;

  localparam logic [1:0] F1 = 2'b00;
  localparam logic [1:0] F2 = 2'b01;
  localparam logic [1:0] F3 = 2'b10;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn;
  logic [1:0] cur_floor;
  logic       moving;
  logic [1:0] goal_floor;
  logic       goal_valid;
  logic [2:0] req_led;
  logic       door_open;
`ifdef CALL_SCHED_DOOR_HOLD_EN
  logic       door_hold;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_open;

  call_scheduler #(.DWELL_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .cur_floor  (cur_floor),
    .moving     (moving),
`ifdef CALL_SCHED_DOOR_HOLD_EN
    .door_hold  (door_hold),
`endif
    .goal_floor (goal_floor),
    .goal_valid (goal_valid),
    .req_led    (req_led),
    .door_open  (door_open)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // drivers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; btn = 3'b000; cur_floor = F1; moving = 1'b0;
`ifdef CALL_SCHED_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    step(2);
    check("rst_goal_valid", 8'(goal_valid), 8'd0);
    check("rst_req_led",    8'(req_led),    8'd0);
    check("rst_door",       8'(door_open),  8'd0);
    check("rst_goal_floor", 8'(goal_floor), 8'(F1));
    rst_n = 1'b1;
    step(1);

    // single call F1 -> F3
    btn = 3'b100; step(1);
    check("s1_led",        8'(req_led),    8'h4);
    check("s1_valid_pre",  8'(goal_valid), 8'd0);
    btn = 3'b000; step(1);
    check("s1_goal",       8'(goal_floor), 8'(F3));
    check("s1_valid",      8'(goal_valid), 8'd1);
    moving = 1'b1; step(2);
    cur_floor = F2; step(1);
    check("s1_goal_pass",  8'(goal_floor), 8'(F3));
    cur_floor = F3; moving = 1'b0; step(1);
    check("s1_arr_door",   8'(door_open),  8'd1);
    check("s1_arr_led",    8'(req_led),    8'd0);
    check("s1_arr_valid",  8'(goal_valid), 8'd0);
    n_open = 1;
    for (int k = 0; k < 20 && door_open; k++) begin
      step(1);
      if (door_open) n_open++;
    end
    check("s1_door_len",   8'(n_open),     8'd8);
    check("s1_idle_valid", 8'(goal_valid), 8'd0);
    check("s1_idle_goal",  8'(goal_floor), 8'(F3));

    // retarget F3 -> F2, then pending F1 and F3 at F2
    cur_floor = F1; rst_n = 1'b0; step(1);
    rst_n = 1'b1; step(1);
    btn = 3'b100; step(1);
    btn = 3'b000; step(1);
    moving = 1'b1;
    btn = 3'b010; step(1);
    check("s2_led",        8'(req_led),    8'h6);
    btn = 3'b000; step(1);
    check("s2_retarget",   8'(goal_floor), 8'(F2));
    check("s2_valid",      8'(goal_valid), 8'd1);
    cur_floor = F2; moving = 1'b0; step(1);
    check("s2_arr_door",   8'(door_open),  8'd1);
    check("s2_arr_led",    8'(req_led),    8'h4);
    btn = 3'b001; step(1);
    check("s3_led",        8'(req_led),    8'h5);
    btn = 3'b000; step(6);
    check("s2_door_7",     8'(door_open),  8'd1);
    step(1);
    check("s2_door_off",   8'(door_open),  8'd0);
    check("s3_goal_up",    8'(goal_floor), 8'(F3));
    check("s3_valid_up",   8'(goal_valid), 8'd1);
    moving = 1'b1; step(1);
    cur_floor = F3; moving = 1'b0; step(1);
    check("s3_arr_door",   8'(door_open),  8'd1);
    check("s3_arr_led",    8'(req_led),    8'h1);
    step(7);
    check("s3_door_7",     8'(door_open),  8'd1);
    step(1);
    check("s3_rev_goal",   8'(goal_floor), 8'(F1));
    check("s3_rev_valid",  8'(goal_valid), 8'd1);

    // invalid position while travelling
    moving = 1'b1; cur_floor = 2'b11; btn = 3'b010; step(1);
    check("inv_valid",     8'(goal_valid), 8'd0);
    check("inv_door",      8'(door_open),  8'd0);
    check("inv_capture",   8'(req_led),    8'h3);
    btn = 3'b000; step(3);
    check("inv_valid_hold", 8'(goal_valid), 8'd0);
    cur_floor = F2; step(1);
    check("inv_back_valid", 8'(goal_valid), 8'd1);
    check("inv_back_goal",  8'(goal_floor), 8'(F1));
    cur_floor = F1; moving = 1'b0; step(1);
    check("inv_arr_led",    8'(req_led),    8'h2);
    step(8);
    check("inv_rev_goal",   8'(goal_floor), 8'(F2));
    check("inv_rev_valid",  8'(goal_valid), 8'd1);
    moving = 1'b1; step(1);
    cur_floor = F2; moving = 1'b0; step(1);
    check("f2_arr_led",     8'(req_led),    8'h0);
    step(8);
    check("f2_idle_door",   8'(door_open),  8'd0);
    check("f2_idle_valid",  8'(goal_valid), 8'd0);

    // press at the idle floor, then re-press during dwell
    btn = 3'b010; step(1);
    check("local_door",     8'(door_open),  8'd1);
    check("local_led",      8'(req_led),    8'h0);
    btn = 3'b000; step(4);
    btn = 3'b010; step(1);
    btn = 3'b000; step(7);
    check("repress_door_7", 8'(door_open),  8'd1);
    check("repress_led",    8'(req_led),    8'h0);
    step(1);
    check("repress_off",    8'(door_open),  8'd0);

    // asynchronous reset during dwell
    btn = 3'b011; step(1);
    check("r_door",         8'(door_open),  8'd1);
    check("r_led",          8'(req_led),    8'h1);
    btn = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    check("r_async_door",   8'(door_open),  8'd0);
    check("r_async_valid",  8'(goal_valid), 8'd0);
    check("r_async_led",    8'(req_led),    8'h0);
    step(1);
    rst_n = 1'b1; step(1);

`ifdef CALL_SCHED_DOOR_HOLD_EN
    door_hold = 1'b1;
    btn = 3'b010; step(1);
    check("hold_door_on",   8'(door_open),  8'd1);
    btn = 3'b000; step(20);
    check("hold_door_20",   8'(door_open),  8'd1);
    door_hold = 1'b0; step(7);
    check("hold_door_7",    8'(door_open),  8'd1);
    step(1);
    check("hold_door_off",  8'(door_open),  8'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
